// File: rtl/iic_txn_sequencer_if.sv
`timescale 1ns/1ps
// Command/response handshake bundle between a command producer and iic_txn_sequencer.
// Latency: none, plain wires.
// Backpressure: cmd_valid/cmd_ready on the command side, rsp_valid/rsp_ready on the response side.
interface iic_txn_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  // Producer / response consumer side.
  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/iic_txn_sequencer.sv
`timescale 1ns/1ps
// Queues I2C commands in a small FIFO and issues them one at a time to an I2C master, returning read bytes.
// Latency: m_start rises in the second cycle after a command is accepted into an empty FIFO with the master idle.
// Backpressure: cmd_ready drops when the FIFO is full; a read at the head waits while an unconsumed rsp_valid is held.
// Optional watchdog on WAIT_DONE is built when IIC_SEQ_TIMEOUT_EN is defined.
module iic_txn_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  iic_txn_sequencer_if.slave   bus,
  output logic                 m_start,
  output logic                 m_rw,
  output logic [6:0]           m_slave_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  output logic                 seq_busy,
  output logic [7:0]           txn_count,
  output logic                 err_timeout
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [FIFO_DEPTH];
  cmd_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            m_start_q, m_start_d;
  logic            m_rw_q, m_rw_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_wdata_q, m_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [7:0]      txn_count_q, txn_count_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            push_en;
  logic            pop_en;
  cmd_t            head;

`ifdef IIC_SEQ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  // Full is taken from the registered count, so a pop never frees a slot for the same cycle.
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign m_start       = m_start_q;
  assign m_rw          = m_rw_q;
  assign m_slave_addr  = m_addr_q;
  assign m_wdata       = m_wdata_q;
  assign txn_count     = txn_count_q;
  assign seq_busy      = (state_q != IDLE) || !fifo_empty;

  // Next-state for FIFO, issue FSM, transaction fields and response register.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    m_start_d   = 1'b0;
    m_rw_d      = m_rw_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    txn_count_d = txn_count_q;
    pop_en      = 1'b0;
    push_en     = bus.cmd_valid && !fifo_full;
`ifdef IIC_SEQ_TIMEOUT_EN
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;
`endif

    if (push_en) begin
      mem_d[wr_ptr_q] = cmd_t'{rw: bus.cmd_rw, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end

    // Consumer handshake; a read completion below takes priority on the same edge.
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A read at the head must not overwrite a response the consumer has not taken yet.
        if (!fifo_empty && !m_busy && (!head.rw || !rsp_valid_q)) begin
          state_d   = ISSUE;
          m_start_d = 1'b1;
          m_rw_d    = head.rw;
          m_addr_d  = head.addr;
          m_wdata_d = head.wdata;
        end
      end
      ISSUE: begin
        pop_en  = 1'b1;
        state_d = WAIT_DONE;
`ifdef IIC_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      WAIT_DONE: begin
        if (m_done) begin
          state_d     = IDLE;
          txn_count_d = txn_count_q + 8'd1;
          if (m_rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = m_rdata;
          end
        end
`ifdef IIC_SEQ_TIMEOUT_EN
        else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + CW'(push_en) - CW'(pop_en);
  end

  // State registers with synchronous reset; reset drops queued and in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      m_start_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m_start_q   <= m_start_d;
      m_rw_q      <= m_rw_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      txn_count_q <= txn_count_d;
    end
  end

`ifdef IIC_SEQ_TIMEOUT_EN
  // Watchdog count and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iic_txn_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for iic_txn_sequencer with a behavioural I2C master.
// Latency: checks m_start in the second cycle after acceptance.
// Backpressure: exercises full FIFO refusal and the read-response stall.
module tb_iic_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_start;
  logic       m_rw;
  logic [6:0] m_slave_addr;
  logic [7:0] m_wdata;
  logic       m_busy;
  logic       m_done;
  logic [7:0] m_rdata;
  logic       seq_busy;
  logic [7:0] txn_count;
  logic       err_timeout;

  iic_txn_sequencer_if bus ();

  iic_txn_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .m_start      (m_start),
    .m_rw         (m_rw),
    .m_slave_addr (m_slave_addr),
    .m_wdata      (m_wdata),
    .m_busy       (m_busy),
    .m_done       (m_done),
    .m_rdata      (m_rdata),
    .seq_busy     (seq_busy),
    .txn_count    (txn_count),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q [$];
  logic [7:0] rsp_q [$];
  int         n_chk   = 0;
  int         n_err   = 0;
  int         n_start = 0;
  bit         mst_stall = 1'b0;
  bit         mst_hold  = 1'b0;
  bit         inflight  = 1'b0;
  logic       cur_rw;
  logic [6:0] cur_addr;
  int         lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural master: acts 2 ns after each rising edge, answers reads with addr ^ 0x7E.
  initial begin
    txn_t e;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      m_done = 1'b0;
      if (rst) begin
        inflight = 1'b0;
      end else if (m_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("m_rw", m_rw, e.rw);
          chk("m_slave_addr", m_slave_addr, e.addr);
          if (!e.rw) chk("m_wdata", m_wdata, e.wdata);
        end
        inflight = 1'b1;
        cur_rw   = m_rw;
        cur_addr = m_slave_addr;
        lat      = 2;
      end else if (inflight && !mst_hold) begin
        if (lat == 0) begin
          m_done   = 1'b1;
          m_rdata  = cur_rw ? ({1'b0, cur_addr} ^ 8'h7E) : 8'hEE;
          inflight = 1'b0;
        end else begin
          lat--;
        end
      end
      m_busy = inflight || mst_stall;
    end
  end

  task automatic push(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
    int   w;
    txn_t t;
    w = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    while (!bus.cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      chk("push_wait", 0, 1);
    end else begin
      t.rw = rw; t.addr = addr; t.wdata = wd;
      exp_q.push_back(t);
      if (rw) rsp_q.push_back({1'b0, addr} ^ 8'h7E);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((seq_busy || inflight) && w < 500);
    if (seq_busy || inflight) chk(tag, 0, 1);
  endtask

  task automatic take_rsp(input string tag);
    int         w;
    logic [7:0] e;
    w = 0;
    while (!bus.rsp_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.rsp_valid) begin
      chk({tag, "_wait"}, 0, 1);
      return;
    end
    if (rsp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
      return;
    end
    e = rsp_q.pop_front();
    chk(tag, bus.rsp_data, e);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_clr"}, bus.rsp_valid, 0);
    chk({tag, "_hold"}, bus.rsp_data, e);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({p, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({p, "_rsp_data"}, bus.rsp_data, 0);
    chk({p, "_m_start"}, m_start, 0);
    chk({p, "_m_rw"}, m_rw, 0);
    chk({p, "_m_addr"}, m_slave_addr, 0);
    chk({p, "_m_wdata"}, m_wdata, 0);
    chk({p, "_txn_count"}, txn_count, 0);
    chk({p, "_seq_busy"}, seq_busy, 0);
    chk({p, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int w;
    int cnt;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("init");

    // Single write and its issue latency.
    push(1'b0, 7'h42, 8'hAA);
    chk("lat_c1", m_start, 0);
    @(negedge clk);
    chk("lat_c2", m_start, 1);
    chk("wr_addr", m_slave_addr, 7'h42);
    chk("wr_wdata", m_wdata, 8'hAA);
    @(negedge clk);
    chk("start_pulse", m_start, 0);
    wait_quiet("wr_quiet");
    chk("wr_cnt", txn_count, 1);
    chk("wr_rsp", bus.rsp_valid, 0);
    chk("wr_starts", n_start, 1);

    // Single read returning 0x3C.
    push(1'b1, 7'h42, 8'h00);
    take_rsp("rd");
    wait_quiet("rd_quiet");
    chk("rd_cnt", txn_count, 2);

    // Fill the FIFO behind a stalled master, then refuse a fifth push.
    mst_stall = 1'b1;
    repeat (2) @(negedge clk);
    base = n_start;
    push(1'b0, 7'h01, 8'h11);
    push(1'b0, 7'h02, 8'h22);
    push(1'b1, 7'h03, 8'h00);
    push(1'b0, 7'h04, 8'h44);
    chk("bp_full", bus.cmd_ready, 0);
    chk("bp_busy", seq_busy, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 7'h05;
    bus.cmd_wdata = 8'h55;
    repeat (3) @(negedge clk);
    chk("bp_refuse", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    chk("bp_no_issue", n_start, base);
    mst_stall = 1'b0;
    wait_quiet("bp_quiet");
    chk("bp_starts", n_start, base + 4);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_cnt", txn_count, 6);
    take_rsp("bp_rd");

    // Two queued reads: the second waits for the first response to be taken.
    mst_stall = 1'b1;
    repeat (2) @(negedge clk);
    base = n_start;
    push(1'b1, 7'h11, 8'h00);
    push(1'b1, 7'h22, 8'h00);
    mst_stall = 1'b0;
    w = 0;
    while (!bus.rsp_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("rs_withheld", n_start, base + 1);
    chk("rs_busy", seq_busy, 1);
    take_rsp("rs_rd1");
    take_rsp("rs_rd2");
    wait_quiet("rs_quiet");
    chk("rs_starts", n_start, base + 2);
    chk("rs_cnt", txn_count, 8);

`ifdef IIC_SEQ_TIMEOUT_EN
    // Master never completes: watchdog returns to IDLE after 16 WAIT_DONE cycles.
    mst_hold = 1'b1;
    push(1'b0, 7'h55, 8'h99);
    w = 0;
    while (!m_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    cnt = 0;
    while (seq_busy && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cycles", cnt, 17);
    chk("to_err", err_timeout, 1);
    chk("to_cnt", txn_count, 8);
    chk("to_rsp", bus.rsp_valid, 0);
    mst_hold = 1'b0;
    repeat (6) @(negedge clk);
    chk("to_late_done", txn_count, 8);
    chk("to_sticky", err_timeout, 1);
`else
    chk("no_wdog", err_timeout, 0);
`endif

    // Reset during WAIT_DONE with two commands queued.
    mst_hold = 1'b1;
    base = n_start;
    push(1'b0, 7'h10, 8'h01);
    w = 0;
    while (!inflight && w < 20) begin
      @(negedge clk);
      w++;
    end
    push(1'b0, 7'h20, 8'h02);
    push(1'b1, 7'h30, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    mst_hold = 1'b0;
    chk_reset("rst");
    repeat (20) @(negedge clk);
    chk("rst_no_start", n_start, base + 1);
    chk("rst_idle", seq_busy, 0);
    chk("rst_cnt", txn_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/iic_txn_sequencer.md
IIC_TXN_SEQUENCER -- requirements
Module: iic_txn_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, watchdog limit in clk cycles; used only when IIC_SEQ_TIMEOUT_EN is defined.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO can accept; equals FIFO not full.
REQ-008 cmd_rw  input  1  0 = write, 1 = read.
REQ-009 cmd_addr  input  7  7-bit slave address.
REQ-010 cmd_wdata  input  8  write byte; ignored for reads.
REQ-011 rsp_valid  output  1  read byte available.
REQ-012 rsp_ready  input  1  consumer takes rsp_data.
REQ-013 rsp_data  output  8  captured read byte.
REQ-014 m_start  output  1  one-cycle start pulse to the I2C master.
REQ-015 m_rw, m_slave_addr, m_wdata  output  1/7/8  transaction fields to the master; held stable from m_start until m_done.
REQ-016 m_busy, m_done, m_rdata  input  1/1/8  master status, completion pulse, read byte.
REQ-017 seq_busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-018 txn_count  output  8  completed-transaction counter.
REQ-019 err_timeout  output  1  sticky watchdog flag.

Function
REQ-020 Command accepted on a rising edge where cmd_valid && cmd_ready; stored in FIFO order.
REQ-021 When the FIFO is full, cmd_ready = 0 and cmd_valid is ignored; no overwrite.
REQ-022 FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states are IDLE, ISSUE, and WAIT_DONE.
REQ-024 IDLE -> ISSUE when the FIFO is non-empty, m_busy = 0, and (the head is a write, or rsp_valid = 0).
REQ-025 A read at the FIFO head stalls in IDLE while rsp_valid = 1; commands behind it are not reordered.
REQ-026 ISSUE: m_start = 1 for exactly one cycle; the head is popped; the m_* fields are registered from the head; next state is WAIT_DONE.
REQ-027 Latency: for a command pushed into an empty FIFO with the master idle, m_start is high in the second cycle after acceptance.
REQ-028 WAIT_DONE -> IDLE on m_done = 1; txn_count increments, wrapping from 255 to 0.
REQ-029 On m_done for a read, rsp_data <= m_rdata and rsp_valid <= 1 on the same edge.
REQ-030 On m_done for a write, rsp_valid and rsp_data are unchanged.
REQ-031 rsp_valid clears on an edge with rsp_valid && rsp_ready; rsp_data holds its value.
REQ-032 A push and a pop in the same cycle leave the occupancy unchanged; a push on a full FIFO with a simultaneous pop is still refused, because cmd_ready is based on registered full.
REQ-033 m_done outside WAIT_DONE is ignored.
REQ-034 All outputs are registered, except cmd_ready and seq_busy, which are decoded from registers.

Reset
REQ-035 On rst the FSM goes to IDLE and the FIFO is emptied.
REQ-036 On rst: m_start = 0, m_rw = 0, m_slave_addr = 0, m_wdata = 0.
REQ-037 On rst: rsp_valid = 0, rsp_data = 0, txn_count = 0, err_timeout = 0, and cmd_ready = 1 on the next cycle.
REQ-038 Reset mid-transaction discards in-flight and queued commands; no m_start is issued until new commands arrive.

Configuration
REQ-039 Macro IIC_SEQ_TIMEOUT_EN, when defined, adds a watchdog counter: cleared on entry to WAIT_DONE, incremented each WAIT_DONE cycle.
REQ-040 With the watchdog enabled, reaching TIMEOUT_CYCLES without m_done forces IDLE and sets err_timeout = 1 (sticky until rst); txn_count and rsp_valid do not change.
REQ-041 Without IIC_SEQ_TIMEOUT_EN, WAIT_DONE waits indefinitely and err_timeout is tied to 0.

Verification
REQ-042 Write: push {rw=0, addr=0x42, wdata=0xAA} to an idle bench master -> m_start pulses once with m_slave_addr=0x42 and m_wdata=0xAA; on m_done, txn_count=1 and rsp_valid stays 0.
REQ-043 Read: push {rw=1, addr=0x42}; the master returns 0x3C -> rsp_valid=1 and rsp_data=0x3C; holding rsp_ready=1 for one cycle clears rsp_valid.
REQ-044 Backpressure: push 4 commands with the master stalled -> cmd_ready=0 and a 5th push is refused; all 4 are issued in order once the master runs.
REQ-045 Read stall: two reads queued with rsp_ready=0 -> the second m_start is withheld until rsp_ready pulses.
REQ-046 Reset: assert rst for one cycle during WAIT_DONE with 2 commands queued -> all outputs return to reset values and no further m_start occurs.
REQ-047 Timeout (macro defined, TIMEOUT_CYCLES=16): m_done withheld -> after 16 WAIT_DONE cycles, err_timeout=1, state is IDLE, and txn_count is unchanged.
